// File: rtl/sdram_arb_pkg.sv
// Shared types and default geometry for the SDRAM frame arbiter.
package sdram_arb_pkg;

    localparam int              DEF_ADDR_W      = 24;
    localparam int              DEF_FIFO_W      = 10;
    localparam int              DEF_FRAME_WORDS = 737280;
    localparam int              DEF_BURST_LEN   = 256;
    localparam int              DEF_RD_LOW      = 128;
    localparam logic [23:0]     DEF_BANK0_BASE  = 24'h000000;
    localparam logic [23:0]     DEF_BANK1_BASE  = 24'h100000;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
    typedef enum logic {GNT_RD, GNT_WR} grant_t;

endpackage

// File: rtl/frame_ptr_ctrl.sv
// Per-direction burst pointer with end-of-frame handling and a frame-sync
// request that is deferred while a burst is in flight.
module frame_ptr_ctrl #(
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 737280,
    parameter int BURST_LEN   = 256,
    parameter bit WRAP        = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              hold,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              full,
    output logic              apply
);

    logic              pend;
    logic [ADDR_W-1:0] ptr_nxt;

    // A sync seen mid-burst waits in pend until the arbiter is idle again.
    assign apply   = !hold && (pend || sync);
    assign ptr_nxt = ptr + ADDR_W'(BURST_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            full <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (apply)
                pend <= 1'b0;
            else if (sync)
                pend <= 1'b1;

            if (apply) begin
                ptr  <= '0;
                full <= 1'b0;
            end else if (advance) begin
                if (ptr_nxt == ADDR_W'(FRAME_WORDS)) begin
                    ptr  <= WRAP ? '0 : ptr_nxt;
                    full <= !WRAP;
                end else begin
                    ptr <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Burst scheduler between camera write FIFO and display read FIFO with
// ping-pong frame buffers; runs entirely in the SDRAM clock domain.
module sdram_frame_arbiter #(
    parameter int              ADDR_W      = sdram_arb_pkg::DEF_ADDR_W,
    parameter int              FRAME_WORDS = sdram_arb_pkg::DEF_FRAME_WORDS,
    parameter int              BURST_LEN   = sdram_arb_pkg::DEF_BURST_LEN,
    parameter int              FIFO_W      = sdram_arb_pkg::DEF_FIFO_W,
    parameter int              RD_LOW      = sdram_arb_pkg::DEF_RD_LOW,
    parameter logic [ADDR_W-1:0] BANK1_BASE = sdram_arb_pkg::DEF_BANK1_BASE
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              init_done,
    input  logic              wr_frame_sync,
    input  logic              rd_frame_sync,
    input  logic [FIFO_W-1:0] wr_fifo_level,
    input  logic [FIFO_W-1:0] rd_fifo_level,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_done,
    output logic              rd_fifo_clr,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_valid
);
    import sdram_arb_pkg::*;

    localparam int RD_ROOM = (1 << FIFO_W) - 1 - BURST_LEN;

    state_t            state, state_nxt;
    grant_t            last_grant;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_addr, rd_addr;
    logic              wr_full, rd_full, wr_apply, rd_apply;
    logic              hold, burst_end, done_bank, done_bank_nxt;
    logic              rd_urgent, wr_ok, rd_ok, issue, issue_we;

    assign hold      = (state != IDLE);
    assign burst_end = (state == BUSY) && cmd_done;

    frame_ptr_ctrl #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN),
                     .WRAP(1'b0)) u_wr_ptr (
        .clk(CLK), .rst_n(RSTn), .sync(wr_frame_sync), .hold(hold),
        .advance(burst_end && cmd_we), .ptr(wr_ptr), .full(wr_full), .apply(wr_apply)
    );

    frame_ptr_ctrl #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN),
                     .WRAP(1'b1)) u_rd_ptr (
        .clk(CLK), .rst_n(RSTn), .sync(rd_frame_sync), .hold(hold),
        .advance(burst_end && !cmd_we), .ptr(rd_ptr), .full(rd_full), .apply(rd_apply)
    );

    assign wr_addr   = (wr_bank ? BANK1_BASE : '0) + wr_ptr;
    assign rd_addr   = (rd_bank ? BANK1_BASE : '0) + rd_ptr;
    assign rd_urgent = frame_valid && (int'(rd_fifo_level) < RD_LOW);
    assign wr_ok     = (int'(wr_fifo_level) >= BURST_LEN) && !wr_full;
    assign rd_ok     = frame_valid && !rd_full && (int'(rd_fifo_level) <= RD_ROOM);
    assign cmd_valid = (state == REQ);

    // Write sync resolves first so a same-cycle read sync sees the new frame.
    assign done_bank_nxt = (wr_apply && wr_full) ? wr_bank : done_bank;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_we  = 1'b0;
        case (state)
            IDLE: begin
                // Skip deciding on a sync cycle so the address uses updated pointers.
                if (init_done && !wr_apply && !rd_apply) begin
                    if (rd_urgent) begin
                        issue = 1'b1;
                    end else if (wr_ok && rd_ok) begin
                        issue    = 1'b1;
                        issue_we = (last_grant == GNT_RD);
                    end else if (wr_ok) begin
                        issue    = 1'b1;
                        issue_we = 1'b1;
                    end else if (rd_ok) begin
                        issue = 1'b1;
                    end
                end
                if (issue)
                    state_nxt = REQ;
            end
            REQ:     if (cmd_ready) state_nxt = BUSY;
            BUSY:    if (cmd_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            last_grant  <= GNT_RD;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            rd_fifo_clr <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            done_bank   <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_fifo_clr <= rd_apply;
            if (issue) begin
                cmd_we   <= issue_we;
                cmd_addr <= issue_we ? wr_addr : rd_addr;
            end
            if (burst_end)
                last_grant <= cmd_we ? GNT_WR : GNT_RD;
            if (wr_apply && wr_full) begin
                done_bank   <= wr_bank;
                wr_bank     <= !wr_bank;
                frame_valid <= 1'b1;
            end
            if (rd_apply)
                rd_bank <= done_bank_nxt;
        end
    end

endmodule
